// File: rtl/reg_alu_seq_pkg.sv
// reg_alu_seq_pkg
// Shared definitions for the register/ALU operation sequencer:
//   - sequencer state encoding (IDLE, READ, EXEC, WB, GAP)
//   - register address width, ALU opcode width, flag vector layout
//   - write-back gating helper used in the WB cycle
// Build option: define REG0_WB_BLOCK_EN to suppress register-array writes
// to address 0 (write-back strobe and done still pulse).
package reg_alu_seq_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned FLAG_W    = 4;
  localparam int unsigned GAP_CNT_W = 4;

  // Bit positions inside the {ZF,CF,OF,SF} flag vector
  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_SF = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_t;

`ifdef REG0_WB_BLOCK_EN
  localparam logic REG0_BLOCK = 1'b1;
`else
  localparam logic REG0_BLOCK = 1'b0;
`endif

  // Register-array write enable for the WB cycle: follows the latched
  // reg_write copy, optionally masked for destination register 0.
  function automatic logic wb_write_enable(input logic             reg_write,
                                           input logic [ADDR_W-1:0] waddr);
    return reg_write & ~(REG0_BLOCK & (waddr == 5'd0));
  endfunction

endpackage

// File: rtl/reg_alu_seq_gap.sv
// seq_gap_counter
// Down-counter that times the GAP state inserted after each write-back.
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   high in the WB cycle: count loads load_val on that edge
//   load_val in 4 number of GAP cycles to time
//   dec      in   high in GAP cycles: count decrements on each edge
//   expire   out  high in the last GAP cycle, i.e. the edge that ends it
//                 brings the count to 0
module seq_gap_counter
  import reg_alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [GAP_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 expire
);

  logic [GAP_CNT_W-1:0] cnt_r;

  // Load on the WB edge, count down while in GAP, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Count reaches 0 on this edge; a stray 0 in GAP also releases the FSM
  assign expire = dec && (cnt_r <= 4'd1);

endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq
// Control sequencer for one register-array / ALU operation:
//   IDLE -> READ (rr_en) -> EXEC (f_en, flags captured) -> WB (wb_en, done,
//   Reg_Write) -> [GAP for IDLE_GAP cycles] -> IDLE.
// Parameter IDLE_GAP (0..15): idle cycles inserted after each write-back.
// Build option: REG0_WB_BLOCK_EN masks Reg_Write when W_Addr == 0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (cmd_ready combinational)
//   cmd_raddr_a/_b, cmd_waddr     command register addresses (5 bits)
//   cmd_alu_op, cmd_reg_write     command opcode and write-back request
//   flags_in                      ALU flags {ZF,CF,OF,SF}, sampled in EXEC
//   R_Addr_A/B, W_Addr, ALU_OP    latched command fields, held until next accept
//   rr_en, f_en, wb_en            one-cycle phase strobes
//   Reg_Write                     register-array write enable (WB only)
//   flags_out                     flags of the last executed operation
//   done                          one-cycle completion pulse (WB)
//   busy                          high in every state except IDLE
module reg_alu_seq
  import reg_alu_seq_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_raddr_a,
  input  logic [ADDR_W-1:0] cmd_raddr_b,
  input  logic [ADDR_W-1:0] cmd_waddr,
  input  logic [OP_W-1:0]   cmd_alu_op,
  input  logic              cmd_reg_write,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              rr_en,
  output logic              f_en,
  output logic              wb_en,
  output logic              Reg_Write,
  output logic [FLAG_W-1:0] flags_out,
  output logic              done,
  output logic              busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(IDLE_GAP);
  localparam logic                 HAS_GAP  = (IDLE_GAP > 0) ? 1'b1 : 1'b0;

  seq_state_t state_r;
  logic       reg_write_r;
  logic       gap_load_s;
  logic       gap_dec_s;
  logic       gap_expire_s;

  // Only the handshake is combinational; it drops in the reset cycle itself
  assign cmd_ready  = (state_r == ST_IDLE) && !rst;
  assign gap_load_s = (state_r == ST_WB);
  assign gap_dec_s  = (state_r == ST_GAP);

  seq_gap_counter u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .dec      (gap_dec_s),
    .expire   (gap_expire_s)
  );

  // Sequencer FSM; every output is registered from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      reg_write_r <= 1'b0;
      R_Addr_A    <= 5'd0;
      R_Addr_B    <= 5'd0;
      W_Addr      <= 5'd0;
      ALU_OP      <= 4'd0;
      flags_out   <= 4'd0;
      rr_en       <= 1'b0;
      f_en        <= 1'b0;
      wb_en       <= 1'b0;
      Reg_Write   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless the entered state sets them
      rr_en     <= 1'b0;
      f_en      <= 1'b0;
      wb_en     <= 1'b0;
      Reg_Write <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            R_Addr_A    <= cmd_raddr_a;
            R_Addr_B    <= cmd_raddr_b;
            W_Addr      <= cmd_waddr;
            ALU_OP      <= cmd_alu_op;
            reg_write_r <= cmd_reg_write;
            rr_en       <= 1'b1;
            busy        <= 1'b1;
            state_r     <= ST_READ;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          f_en    <= 1'b1;
          busy    <= 1'b1;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          flags_out <= flags_in;
          wb_en     <= 1'b1;
          done      <= 1'b1;
          Reg_Write <= wb_write_enable(reg_write_r, W_Addr);
          busy      <= 1'b1;
          state_r   <= ST_WB;
        end
        ST_WB: begin
          if (HAS_GAP) begin
            busy    <= 1'b1;
            state_r <= ST_GAP;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_expire_s) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= ST_GAP;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
